ifu_sub16_pipe: RTL and testbench
=================================

// Module: ifu_sub16_pipe
// PURPOSE
//  Pipelined 16-bit subtract/compare unit for the IFU: diff = a - b - bin, built on the same
//  kill/propagate/generate parallel-prefix carry tree as the IFU adder, run in the borrow direction
//  (a + ~b + ~bin). Serves branch-compare and PC-distance paths. Valid/ready on both sides,
//  3-cycle latency, one result per cycle.
// PARAMETERS
//  TAG_W   4   width of opaque tag carried alongside each operation
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands presented
//  in_ready   out  1      unit accepts operands this cycle
//  in_a       in   16     minuend
//  in_b       in   16     subtrahend
//  in_bin     in   1      borrow-in
//  in_tag     in   TAG_W  passthrough tag
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_diff   out  16     (a - b - bin) mod 2^16
//  out_borrow out  1      1 when unsigned a < b + bin
//  out_zero   out  1      out_diff == 0
//  out_lt     out  1      signed a < b + bin (out_diff[15] ^ out_ovf)
//  out_ovf    out  1      signed overflow: a[15]!=b[15] && diff[15]!=a[15]
//  out_tag    out  TAG_W  tag of this result
// BEHAVIOUR
//  - Reset (async on rst_n low): all stage valids 0; out_valid=0; out_diff, flags, out_tag = 0.
//    Operations in flight at reset are dropped; no output afterwards until new input.
//  - Transfer on a port occurs when valid && ready in the same cycle.
//  - S1: register inverted b, kpg generate per bit with bit 0 seeded by ~bin, prefix levels 1-2.
//    S2: prefix levels 3-4 (spans 4, 8). S3: diff = a ^ ~b ^ carry, carry_out, flags registered.
//  - Latency: operand accepted in cycle N -> out_valid in cycle N+3 when out_ready held 1.
//  - Stall: stage k advances when stage k+1 is empty or draining in the same cycle;
//    in_ready = !s1_valid || s1_advance (combinational, no in_valid->in_ready path).
//    Up to 3 results buffered; with out_ready=0 and all stages full, in_ready=0.
//  - Outputs and tag hold stable while out_valid && !out_ready.
//  - out_borrow = ~carry_out of a + ~b + ~bin. bin=1 and b=0xFFFF yield borrow=1 always.
//  - Accept and emit in the same cycle with full pipe: both transfers happen, no bubble.
//  - Inputs not sampled when in_ready=0; X on operands with in_valid=0 never propagates.
// STRUCTURE
//  - Package ifu_kpg_pkg: kpg_t (2-bit), KPG_K=2'b00, KPG_P=2'b01, KPG_G=2'b11, function
//    kpg_combine(hi, lo) (hi==P ? lo : hi). Shared with the IFU adder.
//  - Sub-module kpg_prefix_level #(SPAN, N): one combinational prefix row, instantiated 4x.
//  - Stage control (valid/advance) in this module; no FSM beyond the per-stage valid bits.
// TESTING
//  - a=0x0005 b=0x0003 bin=0 -> diff 0x0002, borrow 0, zero 0, lt 0, ovf 0, 3 cycles later.
//  - a=0x0000 b=0x0001 bin=0 -> diff 0xFFFF, borrow 1, lt 1, ovf 0.
//  - a=0x8000 b=0x0001 bin=0 -> diff 0x7FFF, borrow 0, ovf 1, lt 1.
//  - a=0x1235 b=0x1234 bin=1 -> diff 0x0000, zero 1, borrow 0; a=b=0x1234 bin=1 -> 0xFFFF, borrow 1.
//  - Back-to-back 8 ops, out_ready=0 for 5 cycles: in_ready drops after 3 accepts, tags emerge
//    in order 0..7, held values unchanged during stall, no loss or duplication.
//  - rst_n low for 1 cycle with 2 ops in flight -> out_valid 0 immediately, stays 0 until new op.
//  - Random 10k ops vs reference model (a-b-bin, flags), random in_valid/out_ready throttling.

Source files
------------

// File: rtl/ifu_kpg_pkg.sv
// Kill/propagate/generate carry-tree primitives shared by the IFU adder and subtractor.
package ifu_kpg_pkg;

   typedef logic [1:0] kpg_t;

   localparam kpg_t KPG_K = 2'b00;
   localparam kpg_t KPG_P = 2'b01;
   localparam kpg_t KPG_G = 2'b11;

   localparam int DW = 16;

   // A propagating upper group defers to whatever the lower group resolved to.
   function automatic kpg_t kpg_combine(input kpg_t hi, input kpg_t lo);
      return (hi == KPG_P) ? lo : hi;
   endfunction

   // Encoding falls out directly: both 0 -> K, one set -> P, both set -> G.
   function automatic kpg_t kpg_gen(input logic x, input logic y);
      return {x & y, x | y};
   endfunction

endpackage

// File: rtl/kpg_prefix_level.sv
// One Kogge-Stone row: each position absorbs the group SPAN bits below it.
module kpg_prefix_level
   import ifu_kpg_pkg::*;
#(
   parameter int SPAN = 1,
   parameter int N    = 16
) (
   input  kpg_t [N-1:0] src,
   output kpg_t [N-1:0] dst
);

   for (genvar i = 0; i < N; i++) begin : g_bit
      if (i >= SPAN) begin : g_comb
         assign dst[i] = kpg_combine(src[i], src[i-SPAN]);
      end else begin : g_pass
         assign dst[i] = src[i];
      end
   end

endmodule

// File: rtl/ifu_sub16_pipe.sv
// Three-stage 16-bit subtract/compare: diff = a + ~b + ~bin through a kpg prefix tree.
// Handshake: a transfer happens on a port in any cycle where valid && ready; in_ready never looks at in_valid.
module ifu_sub16_pipe
   import ifu_kpg_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_a,
   input  logic [DW-1:0]    in_b,
   input  logic             in_bin,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_diff,
   output logic             out_borrow,
   output logic             out_zero,
   output logic             out_lt,
   output logic             out_ovf,
   output logic [TAG_W-1:0] out_tag
);

   logic             s1_valid, s2_valid;
   logic             s1_free, s2_free, s3_free;
   logic             in_fire;

   logic [DW-1:0]    s1_a, s1_nb, s2_a, s2_nb;
   logic             s1_cin, s2_cin;
   logic [TAG_W-1:0] s1_tag, s2_tag;
   kpg_t [DW-1:0]    row0, row1, row2, row3, row4;
   kpg_t [DW-1:0]    s1_row, s2_row;

   logic [DW-1:0]    nb, carry, diff;
   logic             cin, cout, ovf;

   // A stage may take new data when it is empty or its content leaves this cycle.
   assign s3_free  = !out_valid || out_ready;
   assign s2_free  = !s2_valid || s3_free;
   assign s1_free  = !s1_valid || s2_free;
   assign in_ready = s1_free;
   assign in_fire  = in_valid && in_ready;

   assign nb  = ~in_b;
   assign cin = ~in_bin;

   // Bit 0 folds in the carry-in, so every prefix resolves to K or G.
   always_comb begin
      row0    = '0;
      row0[0] = ((in_a[0] & nb[0]) | ((in_a[0] ^ nb[0]) & cin)) ? KPG_G : KPG_K;
      for (int i = 1; i < DW; i++) begin
         row0[i] = kpg_gen(in_a[i], nb[i]);
      end
   end

   kpg_prefix_level #(.SPAN(1), .N(DW)) u_lvl1 (.src(row0),   .dst(row1));
   kpg_prefix_level #(.SPAN(2), .N(DW)) u_lvl2 (.src(row1),   .dst(row2));
   kpg_prefix_level #(.SPAN(4), .N(DW)) u_lvl3 (.src(s1_row), .dst(row3));
   kpg_prefix_level #(.SPAN(8), .N(DW)) u_lvl4 (.src(row3),   .dst(row4));

   always_comb begin
      carry    = '0;
      carry[0] = s2_cin;
      for (int i = 1; i < DW; i++) begin
         carry[i] = (s2_row[i-1] == KPG_G);
      end
   end

   assign diff = s2_a ^ s2_nb ^ carry;
   assign cout = (s2_row[DW-1] == KPG_G);
   // Operand signs differ exactly when a[15] equals the inverted b[15].
   assign ovf  = (s2_a[DW-1] == s2_nb[DW-1]) && (diff[DW-1] != s2_a[DW-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_nb    <= '0;
         s1_cin   <= 1'b0;
         s1_row   <= '0;
         s1_tag   <= '0;
      end else begin
         if (s1_free) s1_valid <= in_valid;
         if (in_fire) begin
            s1_a   <= in_a;
            s1_nb  <= nb;
            s1_cin <= cin;
            s1_row <= row2;
            s1_tag <= in_tag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_a     <= '0;
         s2_nb    <= '0;
         s2_cin   <= 1'b0;
         s2_row   <= '0;
         s2_tag   <= '0;
      end else begin
         if (s2_free) s2_valid <= s1_valid;
         if (s1_valid && s2_free) begin
            s2_a   <= s1_a;
            s2_nb  <= s1_nb;
            s2_cin <= s1_cin;
            s2_row <= row4;
            s2_tag <= s1_tag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_diff   <= '0;
         out_borrow <= 1'b0;
         out_zero   <= 1'b0;
         out_lt     <= 1'b0;
         out_ovf    <= 1'b0;
         out_tag    <= '0;
      end else begin
         if (s3_free) out_valid <= s2_valid;
         if (s2_valid && s3_free) begin
            out_diff   <= diff;
            out_borrow <= ~cout;
            out_zero   <= (diff == '0);
            out_lt     <= diff[DW-1] ^ ovf;
            out_ovf    <= ovf;
            out_tag    <= s2_tag;
         end
      end
   end

endmodule

// File: tb/tb_ifu_sub16_pipe.sv
// Scoreboard bench for ifu_sub16_pipe: integer reference model, random throttling on both ports.
module tb_ifu_sub16_pipe;

   localparam int TAG_W = 4;
   localparam int W     = 20 + TAG_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [15:0]      in_a = '0;
   logic [15:0]      in_b = '0;
   logic             in_bin = 1'b0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [15:0]      out_diff;
   logic             out_borrow, out_zero, out_lt, out_ovf;
   logic [TAG_W-1:0] out_tag;

   ifu_sub16_pipe #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_bin(in_bin), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_diff(out_diff), .out_borrow(out_borrow), .out_zero(out_zero),
      .out_lt(out_lt), .out_ovf(out_ovf), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [W-1:0] exp_q[$];
   int unsigned  acc_q[$];
   int           checks = 0;
   int           errors = 0;
   bit           lat_mode = 1'b0;
   logic         ordy = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Expected result from plain unsigned and signed integer arithmetic.
   function automatic logic [W-1:0] model(input logic [15:0] a, input logic [15:0] b,
                                           input logic bin, input logic [TAG_W-1:0] tag);
      int          ru, rs, sa, sb;
      logic [15:0] d;
      logic        borrow, zero, lt, ovf;
      ru     = int'(a) - int'(b) - int'(bin);
      sa     = $signed(a);
      sb     = $signed(b);
      rs     = sa - sb - int'(bin);
      d      = ru[15:0];
      borrow = (ru < 0);
      zero   = (d == 16'h0);
      ovf    = (rs < -32768) || (rs > 32767);
      lt     = (rs < 0);
      return {d, borrow, zero, lt, ovf, tag};
   endfunction

   task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic bin, input logic [TAG_W-1:0] tag, output bit acc);
      @(negedge clk);
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_bin    = bin;
      in_tag    = tag;
      out_ready = ordy;
      #4;
      acc = in_valid && in_ready;
      if (acc) begin
         exp_q.push_back(model(a, b, bin, tag));
         acc_q.push_back(cyc);
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int k = 0; k < n; k++) step(1'b0, 16'($urandom), 16'($urandom), 1'b0, '0, acc);
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       input logic [TAG_W-1:0] tag);
      bit ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) step(1'b1, a, b, bin, tag, ok);
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready=0 expected accept within 50 cycles");
      end
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 7))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h7FFF;
         3: return 16'h8000;
         default: return 16'($urandom);
      endcase
   endfunction

   // Monitor: pops on every output transfer and checks held outputs during back-pressure.
   initial begin
      logic [W-1:0] cur, prev_out, e;
      bit           prev_stall = 1'b0;
      int unsigned  ac;
      forever begin
         @(negedge clk);
         #4;
         if (!rst_n) begin
            prev_stall = 1'b0;
            continue;
         end
         cur = {out_diff, out_borrow, out_zero, out_lt, out_ovf, out_tag};
         if (prev_stall) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(cur), 32'(prev_out));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got diff=0x%0h tag=%0d expected no output", out_diff, out_tag);
            end else begin
               e  = exp_q.pop_front();
               ac = acc_q.pop_front();
               check("result", 32'(cur), 32'(e));
               if (lat_mode) check("latency", cyc - ac, 32'd3);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = cur;
      end
   end

   initial begin
      bit acc;
      int n_acc, tag_next, sent;

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_outputs", 32'({out_diff, out_borrow, out_zero, out_lt, out_ovf, out_tag}), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, out_ready held high
      lat_mode = 1'b1;
      ordy     = 1'b1;
      send(16'h0005, 16'h0003, 1'b0, 4'd1);
      send(16'h0000, 16'h0001, 1'b0, 4'd2);
      send(16'h8000, 16'h0001, 1'b0, 4'd3);
      send(16'h1235, 16'h1234, 1'b1, 4'd4);
      send(16'h1234, 16'h1234, 1'b1, 4'd5);
      send(16'h0000, 16'hFFFF, 1'b1, 4'd6);
      send(16'hFFFF, 16'hFFFF, 1'b1, 4'd7);
      send(16'h7FFF, 16'hFFFF, 1'b0, 4'd8);
      idle(6);
      lat_mode = 1'b0;

      // Back-pressure: eight ops, out_ready low for five cycles
      ordy     = 1'b0;
      n_acc    = 0;
      tag_next = 0;
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), TAG_W'(tag_next), acc);
         if (acc) begin
            n_acc++;
            tag_next++;
         end
      end
      check("stall_accepts", 32'(n_acc), 32'd3);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      ordy = 1'b1;
      while (tag_next < 8) begin
         send(16'($urandom), 16'($urandom), 1'($urandom), TAG_W'(tag_next));
         tag_next++;
      end
      idle(6);

      // Reset with two operations in flight
      send(16'h4444, 16'h1111, 1'b0, 4'd9);
      send(16'h2222, 16'h3333, 1'b1, 4'd10);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      exp_q.delete();
      acc_q.delete();
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_outputs", 32'({out_diff, out_borrow, out_zero, out_lt, out_ovf, out_tag}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 16'($urandom), 16'($urandom), 1'b0, '0, acc);
         check("postrst_quiet", 32'(out_valid), 32'd0);
      end

      // Random traffic with throttling on both sides
      sent = 0;
      for (int k = 0; k < 60000 && sent < 10000; k++) begin
         ordy = ($urandom_range(0, 9) < 7);
         step(($urandom_range(0, 9) < 7), pick(), pick(), 1'($urandom), TAG_W'($urandom), acc);
         if (acc) sent++;
      end
      check("random_sent", 32'(sent), 32'd10000);

      ordy = 1'b1;
      for (int k = 0; k < 50 && exp_q.size() != 0; k++) idle(1);
      idle(2);
      check("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
